// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words over a req/ack memory port
// into a small first-word-fall-through FIFO that feeds the IF_ID register.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       IFWrite,
    input  logic                       flush,
    input  logic [31:0]                redirect_addr,
    output logic                       inst_valid,
    output logic [31:0]                Instruction_if,
    output logic [31:0]                PC,
    output logic [$clog2(DEPTH):0]     queue_count,
    output logic [1:0]                 fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Handshakes: imem_req rises with a stable imem_addr and stays high until the
    // single-cycle imem_ack that carries imem_rdata; the consumer pops the head
    // entry on any edge where inst_valid & IFWrite are both high and flush is low.

    logic [1:0]    state, state_next;
    logic [31:0]   req_addr, req_addr_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [AW-1:0] head, tail;
    logic [AW:0]   count, count_next;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic        push, pop, room;
    logic [31:0] redirect_pc;
    logic        unused_redirect_bits;

    assign redirect_pc          = {redirect_addr[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_addr[1:0];

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & IFWrite & ~flush;
    assign push       = (state == ST_REQ) & imem_ack & ~flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // A new request may only start when the slot it will land in is guaranteed free.
    assign room = (count_next < FULL_COUNT);

    always_comb begin
        state_next    = state;
        req_addr_next = req_addr;
        fetch_pc_next = fetch_pc;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    fetch_pc_next = redirect_pc;
                    req_addr_next = redirect_pc;
                    state_next    = ST_REQ;
                end else if (room) begin
                    req_addr_next = fetch_pc;
                    state_next    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack && flush) begin
                    fetch_pc_next = redirect_pc;
                    req_addr_next = redirect_pc;
                end else if (flush) begin
                    // Address stays on the bus so the stale handshake can finish.
                    fetch_pc_next = redirect_pc;
                    state_next    = ST_DISCARD;
                end else if (imem_ack) begin
                    fetch_pc_next = req_addr + 32'd4;
                    if (room) begin
                        req_addr_next = req_addr + 32'd4;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (flush) begin
                    fetch_pc_next = redirect_pc;
                end
                if (imem_ack) begin
                    req_addr_next = flush ? redirect_pc : fetch_pc;
                    state_next    = ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            req_addr <= RESET_PC_W;
            fetch_pc <= RESET_PC_W;
        end else begin
            state    <= state_next;
            req_addr <= req_addr_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count_next;
        end
    end

    // Payload storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= req_addr;
            inst_mem[tail] <= imem_rdata;
        end
    end

    assign imem_req       = (state == ST_REQ) || (state == ST_DISCARD);
    assign imem_addr      = req_addr;
    assign Instruction_if = inst_valid ? inst_mem[head] : NOP_INST;
    assign PC             = inst_valid ? pc_mem[head] : fetch_pc;
    assign queue_count    = count;
    assign fsm_state      = state;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: a parameterised-latency memory responder
// plus a linear sequence of steps with hand-computed expectations.
module tb_inst_prefetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        IFWrite;
    logic        flush;
    logic [31:0] redirect_addr;
    logic        inst_valid;
    logic [31:0] Instruction_if;
    logic [31:0] PC;
    logic [2:0]  queue_count;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int wait_cnt = 0;
    logic [31:0] exp_q[$];

    inst_prefetch_queue #(
        .DEPTH(4),
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .IFWrite(IFWrite),
        .flush(flush),
        .redirect_addr(redirect_addr),
        .inst_valid(inst_valid),
        .Instruction_if(Instruction_if),
        .PC(PC),
        .queue_count(queue_count),
        .fsm_state(fsm_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Memory responder: acks after mem_lat wait cycles of a held request.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    end
    always @(negedge clk) begin
        if (reset || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = inst_of(imem_addr);
            wait_cnt   = 0;
        end else begin
            imem_ack = 1'b0;
            wait_cnt = wait_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int lat, input logic pop_en);
        #1 reset = 1'b1;
        mem_lat = lat;
        IFWrite = pop_en;
        flush   = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        IFWrite       = 1'b0;
        flush         = 1'b0;
        redirect_addr = 32'h0;
        mem_lat       = 0;
        repeat (2) @(negedge clk);
        chk("rst_req",   imem_req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_inst",  Instruction_if, NOP);
        chk("rst_pc",    PC, 32'h0);
        chk("rst_count", queue_count, 3'd0);
        #1 reset = 1'b0;

        // Zero-wait memory, no pops: fill to DEPTH then stop requesting.
        step();
        chk("fill_req0",  imem_req, 1'b1);
        chk("fill_addr0", imem_addr, 32'h0);
        chk("fill_cnt0",  queue_count, 3'd0);
        step();
        chk("fill_cnt1",  queue_count, 3'd1);
        chk("fill_addr1", imem_addr, 32'h4);
        chk("fill_valid", inst_valid, 1'b1);
        chk("fill_pc",    PC, 32'h0);
        step();
        chk("fill_cnt2",  queue_count, 3'd2);
        step();
        chk("fill_cnt3",  queue_count, 3'd3);
        step();
        chk("fill_cnt4",  queue_count, 3'd4);
        chk("full_req",   imem_req, 1'b0);
        step();
        chk("full_hold",  queue_count, 3'd4);
        chk("full_req2",  imem_req, 1'b0);
        IFWrite = 1'b1;
        step();
        IFWrite = 1'b0;
        chk("pop_cnt",    queue_count, 3'd3);
        chk("pop_req",    imem_req, 1'b1);
        chk("pop_addr",   imem_addr, 32'h10);
        chk("pop_head",   PC, 32'h4);
        step();
        chk("refill_cnt", queue_count, 3'd4);
        chk("refill_req", imem_req, 1'b0);

        // Redirect while idle and full; low address bits are ignored.
        flush = 1'b1;
        redirect_addr = 32'h0000_0307;
        step();
        flush = 1'b0;
        chk("idle_fl_cnt",  queue_count, 3'd0);
        chk("idle_fl_req",  imem_req, 1'b1);
        chk("idle_fl_addr", imem_addr, 32'h304);
        chk("idle_fl_pc",   PC, 32'h304);
        chk("idle_fl_val",  inst_valid, 1'b0);

        // Zero-wait memory with continuous pops: push+pop keeps count at 1.
        do_reset(0, 1'b1);
        step();
        chk("str_req",   imem_req, 1'b1);
        chk("str_addr",  imem_addr, 32'h0);
        chk("str_valid", inst_valid, 1'b0);
        exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
        while (exp_q.size() != 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            step();
            chk("str_v",    inst_valid, 1'b1);
            chk("str_pc",   PC, e);
            chk("str_inst", Instruction_if, inst_of(e));
            chk("str_cnt",  queue_count, 3'd1);
            chk("str_addr", imem_addr, e + 32'd4);
        end

        // Redirect coinciding with an ack: data dropped, new address next cycle.
        flush = 1'b1;
        redirect_addr = 32'h200;
        step();
        flush = 1'b0;
        chk("ackfl_cnt",  queue_count, 3'd0);
        chk("ackfl_val",  inst_valid, 1'b0);
        chk("ackfl_addr", imem_addr, 32'h200);
        chk("ackfl_pc",   PC, 32'h200);
        chk("ackfl_inst", Instruction_if, NOP);
        step();
        chk("ackfl_v2",   inst_valid, 1'b1);
        chk("ackfl_pc2",  PC, 32'h200);
        chk("ackfl_in2",  Instruction_if, inst_of(32'h200));

        // 3-wait memory, redirect while the first request is outstanding.
        do_reset(3, 1'b1);
        step();
        chk("lat_req",  imem_req, 1'b1);
        chk("lat_addr", imem_addr, 32'h0);
        flush = 1'b1;
        redirect_addr = 32'h100;
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("disc_req",  imem_req, 1'b1);
            chk("disc_addr", imem_addr, 32'h0);
            chk("disc_val",  inst_valid, 1'b0);
            step();
        end
        chk("redir_req",  imem_req, 1'b1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_val",  inst_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("redir_wait", inst_valid, 1'b0);
        end
        step();
        chk("redir_v",    inst_valid, 1'b1);
        chk("redir_pc",   PC, 32'h100);
        chk("redir_inst", Instruction_if, inst_of(32'h100));

        // Asynchronous reset between edges during a request with count=2.
        do_reset(0, 1'b0);
        step();
        step();
        step();
        chk("ar_pre_cnt",  queue_count, 3'd2);
        chk("ar_pre_addr", imem_addr, 32'h8);
        #2 reset = 1'b1;
        #1;
        chk("ar_req",   imem_req, 1'b0);
        chk("ar_valid", inst_valid, 1'b0);
        chk("ar_cnt",   queue_count, 3'd0);
        chk("ar_pc",    PC, 32'h0);
        chk("ar_inst",  Instruction_if, NOP);
        @(negedge clk);
        #1 reset = 1'b0;
        step();
        chk("ar_rel_req",  imem_req, 1'b1);
        chk("ar_rel_addr", imem_addr, 32'h0);
        chk("ar_rel_cnt",  queue_count, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
